// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the core's caches, the arbiter and the single-port RAM.
// master: the arbiter's view. slave: the caches/RAM side that drives requests and RAM status.
interface cache_mem_arbiter_if;
  // icache side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // dcache side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ram_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter for one core's icache and dcache.
// The dcache keeps the grant for a whole block burst; the icache is forced in after
// MAX_DSTREAK consecutive dcache bursts while it waits. RAM strobes are combinational
// from the registered grant state and the grantee's request lines.
module cache_mem_arbiter #(
  parameter int BURST_WORDS = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  cache_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int CW = $clog2(BURST_WORDS + 1);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_WORDS - 1);
  localparam logic [SW-1:0] DSTREAK_MAX = SW'(MAX_DSTREAK);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          ram_err_q, ram_err_d;

  logic          ren, wen, iwait, dwait;
  logic [31:0]   addr, store;
  logic          d_req, force_i;

  assign d_req   = bus.dREN | bus.dWEN;
  assign force_i = bus.iREN && (dstreak_q == DSTREAK_MAX);

  // Registered grant state, burst word count, dcache streak and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dstreak_q <= '0;
      ram_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, whatever the statement order.
      state_q   <= state_d;
      count_q   <= count_d;
      dstreak_q <= dstreak_d;
      ram_err_q <= ram_err_d;
    end
  end

  // Arbitration, burst tracking and RAM/cache handshake outputs.
  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path leaves a latch.
    state_d   = state_q;
    count_d   = count_q;
    dstreak_d = dstreak_q;
    ram_err_d = ram_err_q;
    ren       = 1'b0;
    wen       = 1'b0;
    addr      = '0;
    store     = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d   = IGRANT;
          dstreak_d = '0;
        end
      end

      DGRANT: begin
        // Write wins when both strobes are raised.
        wen   = bus.dWEN;
        ren   = bus.dREN & ~bus.dWEN;
        addr  = bus.daddr;
        store = bus.dstore;
        if (!d_req) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.ramstate == RAM_ACCESS) begin
          dwait = 1'b0;
          if (count_q == LAST_WORD) begin
            state_d = IDLE;
            count_d = '0;
            if (bus.iREN)
              dstreak_d = (dstreak_q == DSTREAK_MAX) ? dstreak_q : dstreak_q + SW'(1);
            else
              dstreak_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else if (bus.ramstate == RAM_ERROR) begin
          ram_err_d = 1'b1;
        end
      end

      IGRANT: begin
        ren  = 1'b1;
        addr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          iwait     = 1'b0;
          state_d   = IDLE;
          dstreak_d = '0;
        end else if (bus.ramstate == RAM_ERROR) begin
          ram_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ramREN   = ren;
  assign bus.ramWEN   = wen;
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ram_err  = ram_err_q;

endmodule
